// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between IFU fetches and LSU loads/stores.
// LSU has priority; a streak limit guarantees IFU forward progress.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LSU_STREAK = 4
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_ifu_valid,
    input  logic [AW-1:0]   i_ifu_addr,
    input  logic            i_ifu_flush,
    output logic            o_ifu_ready,
    output logic            o_ifu_rvalid,
    output logic [DW-1:0]   o_ifu_rdata,
    output logic            o_ifu_rerr,
    input  logic            i_lsu_valid,
    input  logic [AW-1:0]   i_lsu_addr,
    input  logic            i_lsu_wen,
    input  logic [DW-1:0]   i_lsu_wdata,
    input  logic [DW/8-1:0] i_lsu_wmask,
    input  logic [2:0]      i_lsu_read_t,
    output logic            o_lsu_ready,
    output logic            o_lsu_rvalid,
    output logic [DW-1:0]   o_lsu_rdata,
    output logic            o_lsu_rerr,
    output logic            o_mem_valid,
    output logic [AW-1:0]   o_mem_addr,
    output logic            o_mem_wen,
    output logic [DW-1:0]   o_mem_wdata,
    output logic [DW/8-1:0] o_mem_wmask,
    output logic [2:0]      o_mem_read_t,
    input  logic            i_mem_ready,
    input  logic            i_mem_rvalid,
    input  logic [DW-1:0]   i_mem_rdata,
    input  logic            i_mem_rerr
);

    localparam int SW = $clog2(LSU_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(LSU_STREAK);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    typedef enum logic {
        OWN_LSU,
        OWN_IFU
    } owner_t;

    state_t        state;
    owner_t        owner;
    logic [SW-1:0] streak;
    logic          drop;

    logic ifu_req;
    logic lsu_grant;
    logic ifu_grant;
    logic done;
    logic ifu_kill;

    // Grant decision, completion detection and response routing.
    always_comb begin
        ifu_req   = i_ifu_valid && !i_ifu_flush;
        lsu_grant = (state == S_IDLE) && i_lsu_valid
                    && !(ifu_req && (streak == STREAK_MAX));
        ifu_grant = (state == S_IDLE) && !lsu_grant && ifu_req;
        done      = ((state == S_REQ) && i_mem_ready && i_mem_rvalid)
                    || ((state == S_RESP) && i_mem_rvalid);
        // A flush arriving with the response still kills it.
        ifu_kill  = drop || i_ifu_flush;

        o_ifu_ready  = ifu_grant;
        o_lsu_ready  = lsu_grant;
        o_mem_valid  = (state == S_REQ);
        o_ifu_rvalid = done && (owner == OWN_IFU) && !ifu_kill;
        o_lsu_rvalid = done && (owner == OWN_LSU);
        o_ifu_rdata  = i_mem_rdata;
        o_lsu_rdata  = i_mem_rdata;
        o_ifu_rerr   = i_mem_rerr;
        o_lsu_rerr   = i_mem_rerr;
    end

    // Transaction FSM: latch winner's request, hold it on the bus, await data.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= S_IDLE;
            owner        <= OWN_LSU;
            streak       <= '0;
            drop         <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wen    <= 1'b0;
            o_mem_wdata  <= '0;
            o_mem_wmask  <= '0;
            o_mem_read_t <= 3'b000;
        end else begin
            case (state)
                S_IDLE: begin
                    drop <= 1'b0;
                    if (lsu_grant) begin
                        if (!i_ifu_valid)
                            streak <= '0;
                        else if (streak != STREAK_MAX)
                            streak <= streak + 1'b1;
                        owner        <= OWN_LSU;
                        o_mem_addr   <= i_lsu_addr;
                        o_mem_wen    <= i_lsu_wen;
                        o_mem_wdata  <= i_lsu_wdata;
                        o_mem_wmask  <= i_lsu_wmask;
                        o_mem_read_t <= i_lsu_read_t;
                        state        <= S_REQ;
                    end else if (ifu_grant) begin
                        streak       <= '0;
                        owner        <= OWN_IFU;
                        o_mem_addr   <= i_ifu_addr;
                        o_mem_wen    <= 1'b0;
                        o_mem_wdata  <= '0;
                        o_mem_wmask  <= '0;
                        o_mem_read_t <= 3'b010;
                        state        <= S_REQ;
                    end else if (!i_ifu_valid) begin
                        streak <= '0;
                    end
                end
                S_REQ: begin
                    if ((owner == OWN_IFU) && i_ifu_flush)
                        drop <= 1'b1;
                    if (i_mem_ready) begin
                        if (i_mem_rvalid) begin
                            state <= S_IDLE;
                            drop  <= 1'b0;
                        end else begin
                            state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if ((owner == OWN_IFU) && i_ifu_flush)
                        drop <= 1'b1;
                    if (i_mem_rvalid) begin
                        state <= S_IDLE;
                        drop  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    drop  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Inputs change just after posedge; outputs are checked 1ns later.
module tb_mem_port_arbiter;

    logic        i_clock;
    logic        i_reset;
    logic        i_ifu_valid;
    logic [31:0] i_ifu_addr;
    logic        i_ifu_flush;
    logic        o_ifu_ready;
    logic        o_ifu_rvalid;
    logic [31:0] o_ifu_rdata;
    logic        o_ifu_rerr;
    logic        i_lsu_valid;
    logic [31:0] i_lsu_addr;
    logic        i_lsu_wen;
    logic [31:0] i_lsu_wdata;
    logic [3:0]  i_lsu_wmask;
    logic [2:0]  i_lsu_read_t;
    logic        o_lsu_ready;
    logic        o_lsu_rvalid;
    logic [31:0] o_lsu_rdata;
    logic        o_lsu_rerr;
    logic        o_mem_valid;
    logic [31:0] o_mem_addr;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic [2:0]  o_mem_read_t;
    logic        i_mem_ready;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        i_mem_rerr;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .LSU_STREAK(4)) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_ifu_valid  (i_ifu_valid),
        .i_ifu_addr   (i_ifu_addr),
        .i_ifu_flush  (i_ifu_flush),
        .o_ifu_ready  (o_ifu_ready),
        .o_ifu_rvalid (o_ifu_rvalid),
        .o_ifu_rdata  (o_ifu_rdata),
        .o_ifu_rerr   (o_ifu_rerr),
        .i_lsu_valid  (i_lsu_valid),
        .i_lsu_addr   (i_lsu_addr),
        .i_lsu_wen    (i_lsu_wen),
        .i_lsu_wdata  (i_lsu_wdata),
        .i_lsu_wmask  (i_lsu_wmask),
        .i_lsu_read_t (i_lsu_read_t),
        .o_lsu_ready  (o_lsu_ready),
        .o_lsu_rvalid (o_lsu_rvalid),
        .o_lsu_rdata  (o_lsu_rdata),
        .o_lsu_rerr   (o_lsu_rerr),
        .o_mem_valid  (o_mem_valid),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wen    (o_mem_wen),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wmask  (o_mem_wmask),
        .o_mem_read_t (o_mem_read_t),
        .i_mem_ready  (i_mem_ready),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_rerr   (i_mem_rerr)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected grant order for the starvation test: 1 = LSU, 0 = IFU.
    logic [5:0] order;

    initial begin
        i_reset      = 1'b1;
        i_ifu_valid  = 1'b0;
        i_ifu_addr   = '0;
        i_ifu_flush  = 1'b0;
        i_lsu_valid  = 1'b0;
        i_lsu_addr   = '0;
        i_lsu_wen    = 1'b0;
        i_lsu_wdata  = '0;
        i_lsu_wmask  = '0;
        i_lsu_read_t = '0;
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
        i_mem_rerr   = 1'b0;
        order        = 6'b101111;
        step();
        step();

        // reset state
        #1;
        chk1("rst mem_valid", o_mem_valid, 1'b0);
        chk1("rst ifu_ready", o_ifu_ready, 1'b0);
        chk1("rst lsu_ready", o_lsu_ready, 1'b0);
        chk32("rst mem_addr", o_mem_addr, 32'h0);
        chk32("rst read_t", 32'(o_mem_read_t), 32'h0);
        i_reset = 1'b0;
        step();

        // 1: IFU alone
        i_ifu_valid = 1'b1;
        i_ifu_addr  = 32'h8000_0000;
        #1;
        chk1("t1 ifu_ready", o_ifu_ready, 1'b1);
        chk1("t1 lsu_ready", o_lsu_ready, 1'b0);
        step();
        i_ifu_valid = 1'b0;
        i_mem_ready = 1'b1;
        #1;
        chk1("t1 mem_valid", o_mem_valid, 1'b1);
        chk32("t1 mem_addr", o_mem_addr, 32'h8000_0000);
        chk32("t1 wmask", 32'(o_mem_wmask), 32'h0);
        chk1("t1 wen", o_mem_wen, 1'b0);
        chk32("t1 read_t", 32'(o_mem_read_t), 32'h2);
        chk1("t1 ifu_rvalid early", o_ifu_rvalid, 1'b0);
        step();
        i_mem_ready = 1'b0;
        #1;
        chk1("t1 resp wait", o_ifu_rvalid, 1'b0);
        chk1("t1 ready in resp", o_ifu_ready, 1'b0);
        step();
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h0000_0413;
        #1;
        chk1("t1 ifu_rvalid", o_ifu_rvalid, 1'b1);
        chk32("t1 ifu_rdata", o_ifu_rdata, 32'h0000_0413);
        chk1("t1 lsu_rvalid", o_lsu_rvalid, 1'b0);
        step();
        i_mem_rvalid = 1'b0;
        #1;
        chk1("t1 idle mem_valid", o_mem_valid, 1'b0);

        // 2: simultaneous IFU and LSU store
        i_ifu_valid  = 1'b1;
        i_ifu_addr   = 32'h8000_0004;
        i_lsu_valid  = 1'b1;
        i_lsu_addr   = 32'h0000_0010;
        i_lsu_wen    = 1'b1;
        i_lsu_wdata  = 32'hDEAD_BEEF;
        i_lsu_wmask  = 4'b1111;
        i_lsu_read_t = 3'b010;
        #1;
        chk1("t2 lsu_ready", o_lsu_ready, 1'b1);
        chk1("t2 ifu_ready", o_ifu_ready, 1'b0);
        step();
        i_lsu_valid  = 1'b0;
        i_mem_ready  = 1'b1;
        i_mem_rvalid = 1'b1;
        #1;
        chk1("t2 mem_valid", o_mem_valid, 1'b1);
        chk1("t2 wen", o_mem_wen, 1'b1);
        chk32("t2 addr", o_mem_addr, 32'h10);
        chk32("t2 wdata", o_mem_wdata, 32'hDEAD_BEEF);
        chk32("t2 wmask", 32'(o_mem_wmask), 32'hF);
        chk1("t2 lsu_rvalid", o_lsu_rvalid, 1'b1);
        chk1("t2 ifu_rvalid", o_ifu_rvalid, 1'b0);
        step();
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b0;
        #1;
        chk1("t2 ifu next", o_ifu_ready, 1'b1);
        step();
        i_ifu_valid  = 1'b0;
        i_mem_ready  = 1'b1;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h0000_0013;
        #1;
        chk32("t2 ifu addr", o_mem_addr, 32'h8000_0004);
        chk1("t2 ifu_rvalid", o_ifu_rvalid, 1'b1);
        step();
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b0;

        // 3: LSU streak limit
        i_ifu_valid = 1'b1;
        i_lsu_valid = 1'b1;
        i_lsu_wen   = 1'b0;
        for (int g = 0; g < 6; g++) begin
            #1;
            chk1($sformatf("t3 lsu_ready g%0d", g), o_lsu_ready, order[g]);
            chk1($sformatf("t3 ifu_ready g%0d", g), o_ifu_ready, !order[g]);
            step();
            i_mem_ready  = 1'b1;
            i_mem_rvalid = 1'b1;
            #1;
            step();
            i_mem_ready  = 1'b0;
            i_mem_rvalid = 1'b0;
        end
        i_ifu_valid = 1'b0;
        i_lsu_valid = 1'b0;
        step();

        // 4: flush in RESP drops the fetch
        i_ifu_valid = 1'b1;
        i_ifu_addr  = 32'h8000_0100;
        #1;
        chk1("t4 ifu_ready", o_ifu_ready, 1'b1);
        step();
        i_ifu_valid = 1'b0;
        i_mem_ready = 1'b1;
        step();
        i_mem_ready = 1'b0;
        i_ifu_flush = 1'b1;
        #1;
        chk1("t4 flush rvalid", o_ifu_rvalid, 1'b0);
        step();
        i_ifu_flush  = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h0000_0BAD;
        #1;
        chk1("t4 dropped", o_ifu_rvalid, 1'b0);
        chk1("t4 lsu clean", o_lsu_rvalid, 1'b0);
        step();
        i_mem_rvalid = 1'b0;
        i_ifu_valid  = 1'b1;
        i_ifu_flush  = 1'b1;
        #1;
        chk1("t4 idle flush mask", o_ifu_ready, 1'b0);
        i_ifu_flush = 1'b0;
        i_ifu_addr  = 32'h8000_0008;
        #1;
        chk1("t4 refetch ready", o_ifu_ready, 1'b1);
        step();
        i_ifu_valid  = 1'b0;
        i_mem_ready  = 1'b1;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h0000_0513;
        #1;
        chk32("t4 refetch addr", o_mem_addr, 32'h8000_0008);
        chk1("t4 refetch rvalid", o_ifu_rvalid, 1'b1);
        chk32("t4 refetch rdata", o_ifu_rdata, 32'h0000_0513);
        step();
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b0;

        // 5: REQ held without mem_ready
        i_lsu_valid  = 1'b1;
        i_lsu_addr   = 32'h0000_0020;
        i_lsu_wen    = 1'b1;
        i_lsu_wdata  = 32'h1234_5678;
        i_lsu_wmask  = 4'b0011;
        i_lsu_read_t = 3'b001;
        #1;
        chk1("t5 lsu_ready", o_lsu_ready, 1'b1);
        step();
        i_lsu_valid = 1'b0;
        i_lsu_addr  = 32'hFFFF_FFFF;
        i_lsu_wdata = 32'h0;
        i_lsu_wmask = 4'b0000;
        for (int w = 0; w < 5; w++) begin
            #1;
            chk1($sformatf("t5 valid w%0d", w), o_mem_valid, 1'b1);
            chk32($sformatf("t5 addr w%0d", w), o_mem_addr, 32'h20);
            chk32($sformatf("t5 wdata w%0d", w), o_mem_wdata, 32'h1234_5678);
            chk32($sformatf("t5 wmask w%0d", w), 32'(o_mem_wmask), 32'h3);
            step();
        end
        i_mem_ready  = 1'b1;
        i_mem_rvalid = 1'b1;
        i_mem_rerr   = 1'b1;
        #1;
        chk1("t5 lsu_rvalid", o_lsu_rvalid, 1'b1);
        chk1("t5 lsu_rerr", o_lsu_rerr, 1'b1);
        step();
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rerr   = 1'b0;
        #1;
        chk1("t5 back idle", o_mem_valid, 1'b0);

        // 6: reset in REQ, stale response afterwards
        i_ifu_valid = 1'b1;
        i_ifu_addr  = 32'h8000_0200;
        #1;
        chk1("t6 ifu_ready", o_ifu_ready, 1'b1);
        step();
        i_ifu_valid = 1'b0;
        #1;
        chk1("t6 in req", o_mem_valid, 1'b1);
        i_reset = 1'b1;
        step();
        i_reset      = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h0000_0DED;
        #1;
        chk1("t6 mem_valid drop", o_mem_valid, 1'b0);
        chk32("t6 addr cleared", o_mem_addr, 32'h0);
        chk1("t6 stale ifu", o_ifu_rvalid, 1'b0);
        chk1("t6 stale lsu", o_lsu_rvalid, 1'b0);
        step();
        i_mem_rvalid = 1'b0;
        #1;
        chk1("t6 still idle", o_mem_valid, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
